core_l1d_req_router: RTL
========================

// Module: core_l1d_req_router
// PURPOSE
//  Sits between the pipeline data-memory port and the memory side. Accepts one core load/store,
//  classifies it cacheable/non-cacheable against csr_nc_base/csr_nc_mask, forwards it to the L1D or
//  the NC path, waits for that ack and returns registered rdata. Single outstanding request, watchdog.
// PARAMETERS
//  TMO_W   8   watchdog counter width; timeout after 2**TMO_W-1 cycles waiting for downstream ack
// PORTS
//  clk             in   1   clock
//  rst_n           in   1   synchronous active-low reset
//  csr_nc_base     in   32  non-cacheable region base
//  csr_nc_mask     in   32  non-cacheable region compare mask
//  core_req_val    in   1   core request valid; held with fields stable until core_ack
//  core_req_addr   in   32  byte address
//  core_req_cop    in   3   operation (package constants)
//  core_req_wdata  in   32  store data
//  core_req_size   in   3   0=byte 1=half 2=word
//  core_ack        out  1   one-cycle completion pulse
//  core_rdata      out  32  load data, valid with core_ack
//  core_err        out  1   error completion (timeout / misalign), valid with core_ack
//  l1d_req_val/addr/cop/wdata/size  out 1/32/3/32/3  cacheable request to L1D
//  l1d_ack         in   1   L1D completion;  l1d_rdata in 32
//  nc_req_val/addr/cop/wdata/size   out 1/32/3/32/3  non-cacheable request to bus bridge
//  nc_ack          in   1   NC completion;   nc_rdata  in 32
// BEHAVIOUR
//  - Reset: state IDLE, all *_req_val=0, core_ack=0, core_err=0, core_rdata=0, req regs=0, tmo cnt=0.
//  - FSM IDLE -> L1D_REQ | NC_REQ -> RESP -> IDLE.
//  - IDLE & core_req_val: latch addr/cop/wdata/size; nc = ((addr^csr_nc_base)&csr_nc_mask)==0,
//    CSRs sampled only here; next state NC_REQ if nc else L1D_REQ. Mask 0 => everything NC.
//  - *_REQ: selected *_req_val=1 with latched fields, other path val=0; stays until its ack.
//    Ack of non-selected path ignored. On ack: latch rdata, err=0, go RESP; req_val low next cycle.
//  - Downstream ack permitted in first req cycle (min latency): core_req_val@T, req_val@T+1,
//    ack@T+1, core_ack@T+2. core_ack exactly 1 cycle after downstream ack.
//  - RESP: core_ack=1 for exactly one cycle, core_rdata/core_err stable this cycle; then IDLE.
//    core_req_val seen during RESP ignored (core drops/replaces it after ack); new accept from IDLE.
//  - Watchdog: counter clears on entry to *_REQ, increments each *_REQ cycle; reaching all-ones
//    without ack => drop req_val, RESP with core_err=1, core_rdata=0. Late ack afterwards ignored.
//  - Ack and timeout same cycle: ack wins (err=0, data taken).
//  - Stores: core_rdata returned as downstream rdata unchanged (core ignores it).
//  - Sync reset in any state: next edge back to IDLE, req_val dropped; in-flight request discarded.
// CONFIGURATION
//  CORE_L1D_ALIGN_CHK_EN defined: in IDLE, word with addr[1:0]!=0 or half with addr[0]!=0 (or size>2)
//    goes straight to RESP with core_err=1, core_rdata=0, no downstream request (ack 2 cycles after val).
//  Undefined: no check; all requests forwarded, sizing/alignment left to downstream.
// STRUCTURE
//  Package core_l1d_pkg: COP_RD=3'd0, COP_WR=3'd1, SIZE_B/H/W=3'd0/1/2, FSM state typedef
//  (IDLE,L1D_REQ,NC_REQ,RESP). Sub-module core_l1d_tmo_cnt (TMO_W counter: clr, en, expired).
//  Remaining FSM, request regs and output muxing flat in this module.
// TESTING
//  1 nc_base=0x8000_0000 mask=0xF000_0000; word RD 0x0000_0100, l1d_ack same cycle as req, rdata
//    0xDEADBEEF -> l1d_req_val 1 cycle, nc_req_val 0, core_ack 2 cycles after val, rdata DEADBEEF.
//  2 Same CSRs; WR 0x8000_0010 wdata 0x1234 -> nc_req_val with addr/wdata forwarded, held 5 cycles
//    until nc_ack, single core_ack, core_err=0, l1d_req_val never set.
//  3 TMO_W=4, never ack -> req_val high 15 cycles then drops; core_ack with err=1, rdata=0; later
//    l1d_ack ignored, no second core_ack.
//  4 Back-to-back: core re-asserts val the cycle after core_ack -> second request accepted from IDLE,
//    no overlap of req_val across requests; nc_ack asserted while l1d selected -> ignored.
//  5 rst_n low for 1 cycle while L1D_REQ -> l1d_req_val 0 and outputs at reset values next cycle.
//  6 With CORE_L1D_ALIGN_CHK_EN: word RD 0x0000_0102 -> no downstream val, core_ack+err 2 cycles
//    after val; without macro -> forwarded to L1D normally.

Source files
------------

// File: rtl/core_l1d_req_router_pkg.sv
// Shared constants, FSM state type and alignment helper for the L1D request router.
package core_l1d_pkg;

  localparam logic [2:0] COP_RD = 3'd0;
  localparam logic [2:0] COP_WR = 3'd1;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  typedef enum logic [1:0] {IDLE, L1D_REQ, NC_REQ, RESP} state_t;

  function automatic logic misaligned(input logic [31:0] addr, input logic [2:0] size);
    logic bad;
    bad = (size > SIZE_W) ||
          ((size == SIZE_W) && ((addr & 32'd3) != 32'd0)) ||
          ((size == SIZE_H) && ((addr & 32'd1) != 32'd0));
    return bad;
  endfunction

endpackage

// File: rtl/core_l1d_req_router_if.sv
// Core-side and memory-side handshake bundle of the L1D request router.
// slave = router view, master = core + downstream environment view.
interface core_l1d_req_router_if;
  logic        core_req_val;
  logic [31:0] core_req_addr;
  logic [2:0]  core_req_cop;
  logic [31:0] core_req_wdata;
  logic [2:0]  core_req_size;
  logic        core_ack;
  logic [31:0] core_rdata;
  logic        core_err;

  logic        l1d_req_val;
  logic [31:0] l1d_req_addr;
  logic [2:0]  l1d_req_cop;
  logic [31:0] l1d_req_wdata;
  logic [2:0]  l1d_req_size;
  logic        l1d_ack;
  logic [31:0] l1d_rdata;

  logic        nc_req_val;
  logic [31:0] nc_req_addr;
  logic [2:0]  nc_req_cop;
  logic [31:0] nc_req_wdata;
  logic [2:0]  nc_req_size;
  logic        nc_ack;
  logic [31:0] nc_rdata;

  modport slave (
    input  core_req_val, core_req_addr, core_req_cop, core_req_wdata, core_req_size,
    output core_ack, core_rdata, core_err,
    output l1d_req_val, l1d_req_addr, l1d_req_cop, l1d_req_wdata, l1d_req_size,
    input  l1d_ack, l1d_rdata,
    output nc_req_val, nc_req_addr, nc_req_cop, nc_req_wdata, nc_req_size,
    input  nc_ack, nc_rdata
  );

  modport master (
    output core_req_val, core_req_addr, core_req_cop, core_req_wdata, core_req_size,
    input  core_ack, core_rdata, core_err,
    input  l1d_req_val, l1d_req_addr, l1d_req_cop, l1d_req_wdata, l1d_req_size,
    output l1d_ack, l1d_rdata,
    input  nc_req_val, nc_req_addr, nc_req_cop, nc_req_wdata, nc_req_size,
    output nc_ack, nc_rdata
  );
endinterface

// File: rtl/core_l1d_req_router_tmo_cnt.sv
// Watchdog for a pending downstream request; expired flags the cycle whose
// increment would bring the count to all-ones.
module core_l1d_tmo_cnt #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) cnt <= '0;
    else if (en)       cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == {{(W-1){1'b1}}, 1'b0});

endmodule

// File: rtl/core_l1d_req_router.sv
// Routes one core load/store to L1D or the non-cacheable path and returns its completion.
// Optional macro CORE_L1D_ALIGN_CHK_EN: reject misaligned requests with core_err, no downstream access.
module core_l1d_req_router
  import core_l1d_pkg::*;
#(
  parameter int TMO_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           csr_nc_base,
  input  logic [31:0]           csr_nc_mask,
  core_l1d_req_router_if.slave  bus
);

  state_t      state;
  logic [31:0] req_addr, req_wdata, rdata_q;
  logic [2:0]  req_cop, req_size;
  logic        req_bad, l1d_val_q, nc_val_q, ack_q, err_q;
  logic        in_req, in_nc, in_bad, sel_ack, tmo_exp;
  logic [31:0] sel_rdata;

  assign in_req    = (state == L1D_REQ) || (state == NC_REQ);
  assign in_nc     = ((bus.core_req_addr ^ csr_nc_base) & csr_nc_mask) == 32'd0;
  assign sel_ack   = (state == NC_REQ) ? bus.nc_ack   : bus.l1d_ack;
  assign sel_rdata = (state == NC_REQ) ? bus.nc_rdata : bus.l1d_rdata;

`ifdef CORE_L1D_ALIGN_CHK_EN
  assign in_bad = misaligned(bus.core_req_addr, bus.core_req_size);
`else
  assign in_bad = 1'b0;
`endif

  core_l1d_tmo_cnt #(.W(TMO_W)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!in_req),
    .en      (in_req),
    .expired (tmo_exp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_wdata <= '0;
      req_cop   <= '0;
      req_size  <= '0;
      req_bad   <= 1'b0;
      l1d_val_q <= 1'b0;
      nc_val_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_q <= 1'b0;
          if (bus.core_req_val) begin
            req_addr  <= bus.core_req_addr;
            req_wdata <= bus.core_req_wdata;
            req_cop   <= bus.core_req_cop;
            req_size  <= bus.core_req_size;
            req_bad   <= in_bad;
            // Rejected requests pass through L1D_REQ with no valid so the
            // error completion keeps the same two-cycle latency.
            if (in_bad) begin
              state <= L1D_REQ;
            end else if (in_nc) begin
              state    <= NC_REQ;
              nc_val_q <= 1'b1;
            end else begin
              state     <= L1D_REQ;
              l1d_val_q <= 1'b1;
            end
          end
        end
        L1D_REQ, NC_REQ: begin
          if (req_bad || sel_ack || tmo_exp) begin
            l1d_val_q <= 1'b0;
            nc_val_q  <= 1'b0;
            ack_q     <= 1'b1;
            state     <= RESP;
            if (!req_bad && sel_ack) begin
              rdata_q <= sel_rdata;
              err_q   <= 1'b0;
            end else begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        RESP: begin
          ack_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.l1d_req_val   = l1d_val_q;
  assign bus.l1d_req_addr  = req_addr;
  assign bus.l1d_req_cop   = req_cop;
  assign bus.l1d_req_wdata = req_wdata;
  assign bus.l1d_req_size  = req_size;

  assign bus.nc_req_val    = nc_val_q;
  assign bus.nc_req_addr   = req_addr;
  assign bus.nc_req_cop    = req_cop;
  assign bus.nc_req_wdata  = req_wdata;
  assign bus.nc_req_size   = req_size;

  assign bus.core_ack      = ack_q;
  assign bus.core_rdata    = rdata_q;
  assign bus.core_err      = err_q;

endmodule
